// File: rtl/render_pkg.sv
// Shared renderer constants: the 4x4 ordered-dither threshold table,
// the palette/scene codes and the background levels.
package render_pkg;

  // Bayer thresholds, indexed BAYER4[y][x] (row = y, column = x).
  localparam logic [0:3][0:3][3:0] BAYER4 = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6},
    '{4'd3,  4'd11, 4'd1,  4'd9},
    '{4'd15, 4'd7,  4'd13, 4'd5}
  };

  typedef enum logic [1:0] {
    SCENE_GREY = 2'd0,
    SCENE_WARM = 2'd1,
    SCENE_CYAN = 2'd2,
    SCENE_GOLD = 2'd3
  } scene_t;

  localparam logic [1:0] SKY_B     = 2'd1;
  localparam logic [1:0] FLOOR_LVL = 2'd1;

endpackage

// File: rtl/bayer4x4_lut.sv
// 4x4 ordered-dither threshold lookup, purely combinational.
//   x [1:0]  column within the dither cell
//   y [1:0]  row within the dither cell
//   t [3:0]  threshold 0..15
module bayer4x4_lut
  import render_pkg::*;
(
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] t
);

  assign t = BAYER4[y][x];

endmodule

// File: rtl/pixel_output_stage.sv
// Final renderer stage driving the VGA PMOD pins. Two register stages:
// S1 captures the renderer outputs, syncs and the few counter bits needed;
// S2 registers the dithered, palette-mapped colour and the delayed syncs.
// frame_count counts S1 vsync assertions and is not part of the pipeline.
//
// Ports:
//   clk, rst_n                    pixel clock, async active-low reset
//   h_count[10:0], v_count[9:0]   pixel position, aligned with hit/luma
//   hsync_in, vsync_in            raw syncs from the VGA controller
//   display_on_in                 active-video flag
//   hit, luma[5:0]                renderer coverage and intensity
//   scene_select[1:0]             palette select, sampled every pixel
//   r, g, b [1:0]                 dithered colour pins
//   hsync, vsync                  syncs delayed to match r/g/b
//   frame_count[7:0]              frames since reset, wrapping
//
// Build option: define TEMPORAL_DITHER_EN to rotate the dither cell by
// frame_count[1:0] so the pattern cycles over 4 frames.
module pixel_output_stage
  import render_pkg::*;
#(
  parameter int unsigned V_HORIZON = 240,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] h_count,
  input  logic [9:0]  v_count,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        display_on_in,
  input  logic        hit,
  input  logic [5:0]  luma,
  input  logic [1:0]  scene_select,
  output logic [1:0]  r,
  output logic [1:0]  g,
  output logic [1:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  frame_count
);

  localparam logic       SYNC_IDLE = ~SYNC_POL;
  localparam logic [9:0] HORIZON   = 10'(V_HORIZON);

  // Stage 1 registers
  logic       hsync_s1, vsync_s1, disp_s1, hit_s1;
  logic [5:0] luma_s1;
  scene_t     scene_s1;
  logic       h5_s1, v5_s1, floor_s1;
  logic [1:0] x_s1, y_s1;

  logic [1:0] x_nxt, y_nxt;

`ifdef TEMPORAL_DITHER_EN
  assign x_nxt = h_count[1:0] ^ frame_count[1:0];
  assign y_nxt = v_count[1:0] ^ frame_count[1:0];
`else
  assign x_nxt = h_count[1:0];
  assign y_nxt = v_count[1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_s1 <= SYNC_IDLE;
      vsync_s1 <= SYNC_IDLE;
      disp_s1  <= 1'b0;
      hit_s1   <= 1'b0;
      luma_s1  <= 6'd0;
      scene_s1 <= SCENE_GREY;
      h5_s1    <= 1'b0;
      v5_s1    <= 1'b0;
      floor_s1 <= 1'b0;
      x_s1     <= 2'd0;
      y_s1     <= 2'd0;
    end else begin
      hsync_s1 <= hsync_in;
      vsync_s1 <= vsync_in;
      disp_s1  <= display_on_in;
      hit_s1   <= hit;
      luma_s1  <= luma;
      scene_s1 <= scene_t'(scene_select);
      h5_s1    <= h_count[5];
      v5_s1    <= v_count[5];
      floor_s1 <= (v_count >= HORIZON);
      x_s1     <= x_nxt;
      y_s1     <= y_nxt;
    end
  end

  // Frame counter: one count per inactive->active edge of the S1 vsync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= 8'd0;
    end else if (vsync_in == SYNC_POL && vsync_s1 == SYNC_IDLE) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  logic [3:0] thr;

  bayer4x4_lut u_lut (
    .x (x_s1),
    .y (y_s1),
    .t (thr)
  );

  logic [1:0] base, q, half, lvl;
  logic [3:0] frac;
  logic [1:0] r_nxt, g_nxt, b_nxt;

  always_comb begin
    base  = luma_s1[5:4];
    frac  = luma_s1[3:0];
    // Rounding up is suppressed at base 3 so full-scale luma saturates.
    q     = (frac > thr && base != 2'd3) ? base + 2'd1 : base;
    half  = q >> 1;
    lvl   = (h5_s1 ^ v5_s1) ? FLOOR_LVL : 2'd0;
    r_nxt = 2'd0;
    g_nxt = 2'd0;
    b_nxt = 2'd0;
    if (disp_s1) begin
      if (hit_s1) begin
        case (scene_s1)
          SCENE_GREY: begin r_nxt = q;    g_nxt = q;    b_nxt = q;    end
          SCENE_WARM: begin r_nxt = q;    g_nxt = half; b_nxt = 2'd0; end
          SCENE_CYAN: begin r_nxt = 2'd0; g_nxt = q;    b_nxt = q;    end
          default:    begin r_nxt = q;    g_nxt = q;    b_nxt = half; end
        endcase
      end else if (floor_s1) begin
        r_nxt = lvl;
        g_nxt = lvl;
        b_nxt = lvl;
      end else begin
        b_nxt = SKY_B;
      end
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= 2'd0;
      g     <= 2'd0;
      b     <= 2'd0;
      hsync <= SYNC_IDLE;
      vsync <= SYNC_IDLE;
    end else begin
      r     <= r_nxt;
      g     <= g_nxt;
      b     <= b_nxt;
      hsync <= hsync_s1;
      vsync <= vsync_s1;
    end
  end

endmodule

// File: tb/tb_pixel_output_stage.sv
// Random and directed stimulus against a behavioural model of the pixel
// output stage. Each applied pixel yields an expected {r,g,b,hsync,vsync}
// word that is queued and compared two clocks later.
module tb_pixel_output_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        hsync_in, vsync_in, display_on_in, hit;
  logic [5:0]  luma;
  logic [1:0]  scene_select;
  logic [1:0]  r, g, b;
  logic        hsync, vsync;
  logic [7:0]  frame_count;

  pixel_output_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .h_count       (h_count),
    .v_count       (v_count),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .display_on_in (display_on_in),
    .hit           (hit),
    .luma          (luma),
    .scene_select  (scene_select),
    .r             (r),
    .g             (g),
    .b             (b),
    .hsync         (hsync),
    .vsync         (vsync),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  localparam int RESET_WORD = 3;  // black, hsync=vsync=1 (inactive)
  int bayer [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int m_fc;
  int m_vs_prev;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pix(input int h, input int v, input int hs, input int vs,
                                   input int de, input int ht, input int lu, input int sc,
                                   input int fc);
    int x, y, t, base, frac, q, hf, rr, gg, bb, lvl;
    x = h % 4;
    y = v % 4;
`ifdef TEMPORAL_DITHER_EN
    x = (h ^ fc) % 4;
    y = (v ^ fc) % 4;
`endif
    t    = bayer[y * 4 + x];
    base = lu / 16;
    frac = lu % 16;
    q    = (frac > t && base != 3) ? base + 1 : base;
    hf   = q / 2;
    rr = 0; gg = 0; bb = 0;
    if (de != 0) begin
      if (ht != 0) begin
        case (sc)
          0: begin rr = q; gg = q;  bb = q;  end
          1: begin rr = q; gg = hf; bb = 0;  end
          2: begin rr = 0; gg = q;  bb = q;  end
          default: begin rr = q; gg = q; bb = hf; end
        endcase
      end else if (v >= 240) begin
        lvl = (((h / 32) ^ (v / 32)) % 2 != 0) ? 1 : 0;
        rr = lvl; gg = lvl; bb = lvl;
      end else begin
        bb = 1;
      end
    end
    return (rr << 6) | (gg << 4) | (bb << 2) | (hs << 1) | vs;
  endfunction

  task automatic apply(input int h, input int v, input int hs, input int vs, input int de,
                       input int ht, input int lu, input int sc);
    h_count       = 11'(h);
    v_count       = 10'(v);
    hsync_in      = hs[0];
    vsync_in      = vs[0];
    display_on_in = de[0];
    hit           = ht[0];
    luma          = 6'(lu);
    scene_select  = 2'(sc);
    exp_q.push_back(model_pix(h, v, hs, vs, de, ht, lu, sc, m_fc));
    if (vs == 0 && m_vs_prev == 1) m_fc = (m_fc + 1) % 256;
    m_vs_prev = vs;
    @(posedge clk);
    #1;
    check_val("pix", {24'd0, r, g, b, hsync, vsync}, exp_q.pop_front());
    check_val("frame_count", {24'd0, frame_count}, m_fc);
  endtask

  task automatic apply_rand(input int vs);
    apply($urandom_range(0, 2047), $urandom_range(0, 1023), $urandom_range(0, 1), vs,
          ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1),
          $urandom_range(0, 63), $urandom_range(0, 3));
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      h_count       = 11'($urandom);
      v_count       = 10'($urandom);
      hsync_in      = 1'($urandom);
      vsync_in      = 1'($urandom);
      display_on_in = 1'b1;
      hit           = 1'($urandom);
      luma          = 6'($urandom);
      scene_select  = 2'($urandom);
      @(posedge clk);
      #1;
      check_val("rst_pix", {24'd0, r, g, b, hsync, vsync}, RESET_WORD);
      check_val("rst_frame_count", {24'd0, frame_count}, 0);
    end
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(RESET_WORD);
    m_fc      = 0;
    m_vs_prev = 1;
  endtask

  task automatic short_frame(input int len);
    for (int i = 0; i < len; i++) apply_rand((i < 2) ? 0 : 1);
  endtask

  int vs_cur;

  initial begin
    rst_n = 1'b1;
    h_count = '0; v_count = '0; hsync_in = 1'b1; vsync_in = 1'b1;
    display_on_in = 1'b0; hit = 1'b0; luma = '0; scene_select = '0;
    #2;
    do_reset(4);

    // Blank lead-in, then first active pixel.
    apply(0, 0, 1, 1, 0, 1, 63, 0);
    apply(0, 0, 1, 1, 0, 1, 63, 0);
    // Dither points: t=0 -> 3, t=8 -> 2.
    apply(0, 0, 1, 1, 1, 1, 'h28, 0);
    apply(1, 0, 1, 1, 1, 1, 'h28, 0);
    // Full-scale luma saturates at every cell position.
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) apply(x, y, 1, 1, 1, 1, 63, 0);
    // Zero luma.
    for (int x = 0; x < 4; x++) apply(x, 2, 1, 1, 1, 1, 0, 0);
    // Palette walk, then back-to-back scene changes.
    for (int s = 0; s < 4; s++) apply(5, 7, 1, 1, 1, 1, 'h3F, s);
    for (int s = 3; s >= 0; s--) apply(6, 9, 0, 1, 1, 1, 'h3F, s);
    // Background and blanking.
    apply(10, 100, 1, 1, 1, 0, 40, 0);
    apply(32, 300, 1, 1, 1, 0, 40, 0);
    apply(0, 300, 1, 1, 1, 0, 40, 0);
    apply(32, 300, 1, 1, 0, 0, 40, 0);
    apply(3, 3, 1, 1, 0, 1, 63, 1);
    apply(0, 240, 1, 1, 1, 0, 0, 2);
    apply(0, 239, 1, 1, 1, 0, 0, 2);
    apply(0, 256, 1, 1, 1, 0, 0, 2);
    apply(0, 1023, 0, 1, 1, 0, 0, 3);
    apply(5, 5, 1, 1, 1, 1, 4, 0);
    apply(5, 5, 1, 1, 1, 1, 8, 1);

    // Random pixels with occasional vsync toggles.
    vs_cur = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) vs_cur = 1 - vs_cur;
      apply_rand(vs_cur);
    end

    // Reset in the middle of activity, then continue.
    for (int i = 0; i < 10; i++) apply_rand(i % 2);
    do_reset(3);
    for (int i = 0; i < 20; i++) apply_rand(1);

    // Three short frames, then enough more to wrap the counter.
    for (int f = 0; f < 3; f++) short_frame(40);
    check_val("frames_3", {24'd0, frame_count}, 3);
    for (int f = 0; f < 256; f++) short_frame(4);
    check_val("frames_wrap", {24'd0, frame_count}, 3);
    // Vsync held active for a long stretch counts once.
    for (int i = 0; i < 30; i++) apply_rand(0);
    for (int i = 0; i < 5; i++) apply_rand(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
